// File: rtl/pipe_mac_if.sv
// -----------------------------------------------------------------------------
// pipe_mac_if
// Handshake/data bundle for the pipelined multiply-accumulate block.
//
// Parameters: AW, BW (signed operand widths), CW (signed addend/result width).
//
// Signals:
//   in_valid/in_ready        operand beat handshake
//   in_a, in_b, in_c         signed operands A, B and addend C
//   in_save                  save flag carried with the beat
//   flush                    discard every in-flight beat
//   out_valid/out_ready      result beat handshake
//   out_r, out_save          result and its carried save flag
//   saved_r                  last result transferred with save=1
//   count                    number of valid beats held in the pipeline
//
// Modports: master = producer/consumer side, slave = pipe_mac.
// -----------------------------------------------------------------------------
interface pipe_mac_if #(
    parameter int AW = 8,
    parameter int BW = 8,
    parameter int CW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [AW-1:0] in_a;
    logic signed [BW-1:0] in_b;
    logic signed [CW-1:0] in_c;
    logic                 in_save;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic        [CW-1:0] out_r;
    logic                 out_save;
    logic        [CW-1:0] saved_r;
    logic        [2:0]    count;

    modport master (
        output in_valid, in_a, in_b, in_c, in_save, flush, out_ready,
        input  in_ready, out_valid, out_r, out_save, saved_r, count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_save, flush, out_ready,
        output in_ready, out_valid, out_r, out_save, saved_r, count
    );
endinterface

// File: rtl/pipe_mac.sv
// -----------------------------------------------------------------------------
// pipe_mac
// Elastic pipelined multiply-accumulate: r = A*B + C, carried through STAGES
// register stages with per-stage valid bits so bubbles collapse while the tail
// is stalled. The whole product/sum is formed in front of stage 0, so a beat
// accepted on edge N appears at the tail after edge N+STAGES-1.
//
// Parameters: AW, BW (2..16), CW (4..32), STAGES (1..6).
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous, active-high reset (overrides flush and handshakes)
//   bus   pipe_mac_if.slave (handshakes, operands, result, saved_r, count)
//
// Configuration macro:
//   PIPE_MAC_SAT_EN  defined   -> out-of-range results clamp to the CW range
//                    undefined -> results wrap to the low CW bits
// -----------------------------------------------------------------------------
module pipe_mac #(
    parameter int AW     = 8,
    parameter int BW     = 8,
    parameter int CW     = 16,
    parameter int STAGES = 3
) (
    input  logic       clk,
    input  logic       rst,
    pipe_mac_if.slave  bus
);
    // Full-precision width: one guard bit above the wider of product and addend.
    localparam int PW = ((AW + BW) > CW ? (AW + BW) : CW) + 1;

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] c_ext;
    logic signed [PW-1:0] sum_full;
    logic        [CW-1:0] result;

    assign a_ext    = {{(PW-AW){bus.in_a[AW-1]}}, bus.in_a};
    assign b_ext    = {{(PW-BW){bus.in_b[BW-1]}}, bus.in_b};
    assign c_ext    = {{(PW-CW){bus.in_c[CW-1]}}, bus.in_c};
    assign sum_full = a_ext * b_ext + c_ext;

`ifdef PIPE_MAC_SAT_EN
    // In range exactly when every bit from the CW sign position up is equal.
    logic in_range;
    assign in_range = (&sum_full[PW-1:CW-1]) || !(|sum_full[PW-1:CW-1]);

    always_comb begin
        if (in_range)
            result = sum_full[CW-1:0];
        else if (sum_full[PW-1])
            result = {1'b1, {(CW-1){1'b0}}};
        else
            result = {1'b0, {(CW-1){1'b1}}};
    end
`else
    assign result = sum_full[CW-1:0];
`endif

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [STAGES-1:0] stg_v;
    logic [CW-1:0]     stg_r [STAGES];
    logic              stg_s [STAGES];
    logic [STAGES-1:0] adv;
    logic [CW-1:0]     saved_q;
    logic [2:0]        cnt_q;
    logic              accept;
    logic              xfer;

    // Stage k advances unless it and every stage downstream of it are full
    // while the consumer stalls; this is what lets bubbles collapse.
    // NOTE: every variable written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            logic full_tail;
            full_tail = 1'b1;
            for (int j = k; j < STAGES; j++)
                full_tail = full_tail && stg_v[j];
            adv[k] = bus.out_ready || !full_tail;
        end
    end

    assign accept = bus.in_valid && adv[0];
    assign xfer   = stg_v[STAGES-1] && bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its upstream neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset too, because the tail payload
            // is visible on out_r and must read zero after reset.
            stg_v   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_r[k] <= '0;
                stg_s[k] <= 1'b0;
            end
            saved_q <= '0;
            cnt_q   <= '0;
        end else if (bus.flush) begin
            stg_v <= '0;
            cnt_q <= '0;
        end else begin
            if (adv[0]) begin
                stg_v[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    stg_r[0] <= result;
                    stg_s[0] <= bus.in_save;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    stg_v[k] <= stg_v[k-1];
                    // Payload moves only with a real beat, so an emptied tail
                    // keeps its last value rather than picking up junk.
                    if (stg_v[k-1]) begin
                        stg_r[k] <= stg_r[k-1];
                        stg_s[k] <= stg_s[k-1];
                    end
                end
            end

            if (xfer && stg_s[STAGES-1])
                saved_q <= stg_r[STAGES-1];

            case ({accept, xfer})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = stg_v[STAGES-1];
    assign bus.out_r     = stg_r[STAGES-1];
    assign bus.out_save  = stg_s[STAGES-1];
    assign bus.saved_r   = saved_q;
    assign bus.count     = cnt_q;
endmodule

// File: doc/pipe_mac.md
PIPE_MAC -- requirements
Module: pipe_mac

Interface
REQ-001 Parameter AW, default 8: signed A operand width, 2..16.
REQ-002 Parameter BW, default 8: signed B operand width, 2..16.
REQ-003 Parameter CW, default 16: signed addend/result width, 4..32.
REQ-004 Parameter STAGES, default 3: pipeline register depth, 1..6.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  operand beat offered.
REQ-008 in_ready  out  1  pipeline accepts beat this cycle.
REQ-009 in_a  in  AW  signed A; in_b  in  BW  signed B; in_c  in  CW  signed addend.
REQ-010 in_save  in  1  save flag carried with the beat.
REQ-011 flush  in  1  discard all in-flight beats.
REQ-012 out_valid  out  1  result beat present at pipeline tail.
REQ-013 out_ready  in  1  consumer takes result.
REQ-014 out_r  out  CW  result; out_save  out  1  flag carried with result.
REQ-015 saved_r  out  CW  last result transferred with save=1.
REQ-016 count  out  3  number of valid beats held in pipeline, 0..STAGES.

Function
REQ-017 Result SHALL be sign-extend(in_a*in_b) + sign-extend(in_c), computed at max(AW+BW,CW)+1 bits, then reduced to CW per REQ-032/033.
REQ-018 Pipeline SHALL be STAGES register stages, each with own valid bit, payload and save flag; stage STAGES-1 drives out_*.
REQ-019 Accept on edge where in_valid && in_ready; transfer out on edge where out_valid && out_ready.
REQ-020 Stage k SHALL advance when stage k+1 is empty or advancing; tail advances when out_ready or empty.
REQ-021 Bubbles SHALL collapse: an empty stage accepts from upstream even while tail is stalled.
REQ-022 in_ready SHALL equal (stage 0 empty) || (stage 0 advancing); combinational from out_ready allowed.
REQ-023 Unstalled latency: beat accepted at edge N SHALL appear on out_* after edge N+STAGES-1 (out_valid high in cycle following that edge).
REQ-024 Beat order SHALL be preserved; no beat dropped or duplicated under any out_ready pattern.
REQ-025 out_r/out_save SHALL hold stable while out_valid && !out_ready.
REQ-026 count SHALL increment on accept-only, decrement on transfer-only, hold on both or neither.
REQ-027 Full (count==STAGES, tail stalled): in_ready SHALL be 0; simultaneous accept and transfer at full SHALL be permitted.
REQ-028 saved_r SHALL load out_r on the transfer edge when out_save=1; otherwise hold.
REQ-029 flush SHALL clear all valid bits and count on that edge; in-cycle accept and transfer SHALL be ignored; saved_r SHALL hold.
REQ-030 Arithmetic may be split across stages freely provided REQ-023 latency holds.

Reset
REQ-031 On rst edge: all stage valids 0, out_valid 0, out_r 0, out_save 0, saved_r 0, count 0; rst overrides flush and any handshake in that cycle; in_ready SHALL be 1 in cycle after reset release.

Configuration
REQ-032 Macro PIPE_MAC_SAT_EN defined: result outside CW signed range SHALL clamp to 2^(CW-1)-1 or -2^(CW-1).
REQ-033 PIPE_MAC_SAT_EN undefined: result SHALL be the low CW bits (two's-complement wrap).

Verification (AW=8, BW=8, CW=16, STAGES=3)
REQ-034 A=0xFD(-3), B=7, C=100, out_ready=1 -> out_r=0x004F three cycles after accept, count returns 0.
REQ-035 A=0x80, B=0x80, C=0x7FFF -> out_r=0x7FFF with PIPE_MAC_SAT_EN, 0xBFFF without.
REQ-036 out_ready=0, offer 5 beats back-to-back -> 3 accepted, in_ready=0, count=3; raise out_ready -> all beats emerge in order, one per cycle.
REQ-037 Beat with save=1 (A=2,B=3,C=4) then save=0 beat (A=1,B=1,C=0) -> saved_r=0x000A, unchanged by second transfer.
REQ-038 Assert flush with count=2, then rst with count=3 -> each edge gives out_valid=0, count=0; next accept yields correct result at latency 3.
